wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DW, default 16, width of each requester data word and of the write-back output.
REQ-002 SHALL have parameter CNT_W, default 8, width of the saturating grant counters.
REQ-003 SHALL have port clk input 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset input 1: synchronous, active-high reset.
REQ-005 SHALL have port s_valid input 1: S-path requester has a word.
REQ-006 SHALL have port s_data input DW: S-path word, mapped to mux upper half.
REQ-007 SHALL have port s_ready output 1: S word accepted this cycle when s_valid&&s_ready.
REQ-008 SHALL have port ds_valid input 1: DS-path requester has a word.
REQ-009 SHALL have port ds_data input DW: DS-path word, mapped to mux lower half.
REQ-010 SHALL have port ds_ready output 1: DS word accepted this cycle when ds_valid&&ds_ready.
REQ-011 SHALL have port wb_valid output 1: registered write-back word present.
REQ-012 SHALL have port wb_data output DW: registered write-back word.
REQ-013 SHALL have port wb_sel output 1: select that produced wb_data (0=S, 1=DS).
REQ-014 SHALL have port wb_ready input 1: consumer accepts wb_data when wb_valid&&wb_ready.
REQ-015 SHALL have ports s_cnt and ds_cnt, output CNT_W each: saturating count of words granted per requester.

Function
REQ-016 SHALL implement FSM states IDLE (output empty), FULL (output holds word, consumer not yet taken it).
REQ-017 SHALL accept at most one requester word per cycle; s_ready and ds_ready never both 1.
REQ-018 SHALL grant only when the output register is empty or being drained the same cycle (wb_valid==0 or wb_ready==1).
REQ-019 SHALL, when both valid, grant round-robin: requester not granted last wins; last_grant resets to DS so S wins first tie.
REQ-020 SHALL, when only one valid, grant it regardless of last_grant.
REQ-021 SHALL load wb_data/wb_sel on the grant edge; latency is 1 cycle from accepted request to wb_valid.
REQ-022 SHALL sustain one word per cycle with wb_ready held 1 (drain and refill same edge).
REQ-023 SHALL hold wb_data, wb_sel, wb_valid stable while wb_valid==1 and wb_ready==0.
REQ-024 SHALL transition IDLE->FULL on grant, FULL->IDLE on drain without grant, FULL->FULL on drain with grant.
REQ-025 SHALL increment s_cnt/ds_cnt on each accepted word and saturate at all-ones without wrap.
REQ-026 SHALL make ready outputs combinational from valid inputs, state, last_grant and wb_ready.

Reset
REQ-027 SHALL, while reset==1 at a clock edge, set state=IDLE, wb_valid=0, wb_data=0, wb_sel=0, last_grant=DS, s_cnt=0, ds_cnt=0.
REQ-028 SHALL drive s_ready=0 and ds_ready=0 while reset==1.
REQ-029 SHALL discard any word held in the output register when reset asserts mid-operation.

Configuration
REQ-030 SHALL, with WB_ARB_FIXED_PRIO_EN defined, replace round-robin with fixed priority: S always wins a tie; last_grant unused.
REQ-031 SHALL, without WB_ARB_FIXED_PRIO_EN, use round-robin per REQ-019.

Structure
REQ-032 SHALL take state encodings (IDLE, FULL) and select constants (SEL_S=0, SEL_DS=1) from shared package wb_arb_pkg.
REQ-033 SHALL instantiate mux_2x1 as the sole sub-module for data selection, fed {s_data, ds_data} with S=wb_sel-next.

Verification
REQ-034 SHALL cover: reset, then s_valid=1 s_data=16'hA5A5 -> next cycle wb_valid=1, wb_data=16'hA5A5, wb_sel=0, s_cnt=1.
REQ-035 SHALL cover: both valid, wb_ready=1, 4 cycles -> wb_sel sequence 0,1,0,1; s_cnt=2, ds_cnt=2.
REQ-036 SHALL cover: wb_ready=0 with word held 5 cycles -> wb_data unchanged, s_ready=ds_ready=0 throughout.
REQ-037 SHALL cover: WB_ARB_FIXED_PRIO_EN defined, both valid 4 cycles -> wb_sel 0,0,0,0; ds_cnt=0.
REQ-038 SHALL cover: s_valid=1 for 300 cycles with CNT_W=8 -> s_cnt stops at 255.
REQ-039 SHALL cover: reset asserted while FULL -> next cycle wb_valid=0, counters 0, following tie grants S.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the write-back arbiter: FSM state encoding,
// select constants and the round-robin tie-break helper.
package wb_arb_pkg;

    // Output register state: IDLE = empty, FULL = holding a word not yet taken
    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    // Select values carried on wb_sel and used as the mux select
    localparam logic SEL_S  = 1'b0;
    localparam logic SEL_DS = 1'b1;

    // Round-robin choice: S wins unless DS also requests and S was granted last
    function automatic logic rr_pick_s(input logic s_valid,
                                       input logic ds_valid,
                                       input logic last_grant);
        return s_valid && (!ds_valid || (last_grant == SEL_DS));
    endfunction

endpackage

// File: rtl/mux_2x1.sv
// Two-way word selector. The packed input carries the S word in the upper
// half and the DS word in the lower half; select SEL_S picks the upper half.
module mux_2x1
    import wb_arb_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [2*DW-1:0] d,
    input  logic            s,
    output logic [DW-1:0]   y
);

    assign y = (s == SEL_S) ? d[2*DW-1:DW] : d[DW-1:0];

endmodule

// File: rtl/wb_arbiter.sv
// Two-requester write-back arbiter with a single registered output slot.
// S and DS requesters compete for the slot; ties are broken round-robin,
// or by fixed S priority when WB_ARB_FIXED_PRIO_EN is defined.
// Per-requester grant counters saturate at all-ones.
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DW    = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    input  logic [DW-1:0]    s_data,
    output logic             s_ready,
    input  logic             ds_valid,
    input  logic [DW-1:0]    ds_data,
    output logic             ds_ready,
    output logic             wb_valid,
    output logic [DW-1:0]    wb_data,
    output logic             wb_sel,
    input  logic             wb_ready,
    output logic [CNT_W-1:0] s_cnt,
    output logic [CNT_W-1:0] ds_cnt
);

    state_t        state;
    logic          room;
    logic          grant_s;
    logic          grant_ds;
    logic          grant;
    logic          sel_next;
    logic [DW-1:0] mux_y;

`ifndef WB_ARB_FIXED_PRIO_EN
    // Requester granted most recently; resets to DS so S wins the first tie
    logic          last_grant;
`endif

    // Grant decision: only when the slot is empty or draining this cycle
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        room     = (state == IDLE) || wb_ready;
        grant_s  = 1'b0;
        grant_ds = 1'b0;
        if (!reset && room) begin
`ifdef WB_ARB_FIXED_PRIO_EN
            grant_s = s_valid;
`else
            grant_s = rr_pick_s(s_valid, ds_valid, last_grant);
`endif
            grant_ds = ds_valid && !grant_s;
        end
    end

    assign s_ready  = grant_s;
    assign ds_ready = grant_ds;
    assign grant    = grant_s || grant_ds;
    assign sel_next = grant_ds ? SEL_DS : SEL_S;

    mux_2x1 #(
        .DW(DW)
    ) u_mux (
        .d ({s_data, ds_data}),
        .s (sel_next),
        .y (mux_y)
    );

    // Output slot FSM: load on grant, release on drain without refill
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state    <= IDLE;
            wb_valid <= 1'b0;
            // NOTE: the data register is cleared on reset so wb_data never shows a stale word after reset.
            wb_data  <= '0;
            wb_sel   <= SEL_S;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        state    <= FULL;
                        wb_valid <= 1'b1;
                        wb_data  <= mux_y;
                        wb_sel   <= sel_next;
                    end
                end
                FULL: begin
                    if (grant) begin
                        wb_data <= mux_y;
                        wb_sel  <= sel_next;
                    end else if (wb_ready) begin
                        state    <= IDLE;
                        wb_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifndef WB_ARB_FIXED_PRIO_EN
    // Remember the winner of each grant for the next tie
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= SEL_DS;
        end else if (grant) begin
            last_grant <= sel_next;
        end
    end
`endif

    // Saturating per-requester grant counters
    always_ff @(posedge clk) begin
        if (reset) begin
            s_cnt  <= '0;
            ds_cnt <= '0;
        end else begin
            if (grant_s && (s_cnt != '1)) begin
                s_cnt <= s_cnt + 1'b1;
            end
            if (grant_ds && (ds_cnt != '1)) begin
                ds_cnt <= ds_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios with literal
// expectations plus a long randomized run compared every cycle against a
// queue-based model of the output slot, tie-break and counters.
module tb_wb_arbiter;

    localparam int DW    = 16;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             s_valid;
    logic [DW-1:0]    s_data;
    logic             s_ready;
    logic             ds_valid;
    logic [DW-1:0]    ds_data;
    logic             ds_ready;
    logic             wb_valid;
    logic [DW-1:0]    wb_data;
    logic             wb_sel;
    logic             wb_ready;
    logic [CNT_W-1:0] s_cnt;
    logic [CNT_W-1:0] ds_cnt;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    wb_arbiter #(
        .DW   (DW),
        .CNT_W(CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .ds_valid(ds_valid),
        .ds_data (ds_data),
        .ds_ready(ds_ready),
        .wb_valid(wb_valid),
        .wb_data (wb_data),
        .wb_sel  (wb_sel),
        .wb_ready(wb_ready),
        .s_cnt   (s_cnt),
        .ds_cnt  (ds_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the output slot is a queue of {sel, data} holding at
    // most one entry; counters are plain integers clamped at CMAX.
    logic [DW:0] outq[$];
    bit          m_last_ds = 1'b1;
    int          m_scnt    = 0;
    int          m_dscnt   = 0;

    initial begin
        wait (started);
        forever begin
            bit room, prefer_s, gs, gd;
            @(negedge clk);
            room = (outq.size() == 0) || wb_ready;
`ifdef WB_ARB_FIXED_PRIO_EN
            prefer_s = 1'b1;
`else
            prefer_s = m_last_ds;
`endif
            gs = !reset && room && s_valid && (!ds_valid || prefer_s);
            gd = !reset && room && ds_valid && !gs;

            if (s_valid)  check("m_s_ready",  {31'd0, s_ready},  {31'd0, gs});
            if (ds_valid) check("m_ds_ready", {31'd0, ds_ready}, {31'd0, gd});
            check("m_one_ready", {31'd0, s_ready && ds_ready}, 32'd0);
            check("m_wb_valid", {31'd0, wb_valid}, {31'd0, outq.size() != 0});
            if (outq.size() != 0)
                check("m_wb_word", {15'd0, wb_sel, wb_data}, {15'd0, outq[0]});
            check("m_s_cnt",  {24'd0, s_cnt},  m_scnt);
            check("m_ds_cnt", {24'd0, ds_cnt}, m_dscnt);

            // Advance the model to what the coming edge must produce
            if (reset) begin
                outq.delete();
                m_last_ds = 1'b1;
                m_scnt    = 0;
                m_dscnt   = 0;
            end else begin
                if (outq.size() != 0 && wb_ready) void'(outq.pop_front());
                if (gs) begin
                    outq.push_back({1'b0, s_data});
                    if (m_scnt < CMAX) m_scnt++;
                    m_last_ds = 1'b0;
                end
                if (gd) begin
                    outq.delete();
                    outq.push_back({1'b1, ds_data});
                    if (m_dscnt < CMAX) m_dscnt++;
                    m_last_ds = 1'b1;
                end
            end
        end
    end

    initial begin
        logic exp_sel[4];
        reset    = 1'b1;
        s_valid  = 1'b0;
        s_data   = '0;
        ds_valid = 1'b0;
        ds_data  = '0;
        wb_ready = 1'b0;
        tick();
        started = 1'b1;
        s_valid = 1'b1;
        tick();
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_data", {16'd0, wb_data}, 32'd0);

        // First word from S: one-cycle latency, sel 0, count 1
        reset   = 1'b0;
        s_data  = 16'hA5A5;
        tick();
        s_valid = 1'b0;
        check("first_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("first_wb_data", {16'd0, wb_data}, 32'h0000A5A5);
        check("first_wb_sel", {31'd0, wb_sel}, 32'd0);
        check("first_s_cnt", {24'd0, s_cnt}, 32'd1);

        // Consumer stalls: word held, nobody granted
        s_valid  = 1'b1;
        s_data   = 16'h1111;
        ds_valid = 1'b1;
        ds_data  = 16'h2222;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_wb_data", {16'd0, wb_data}, 32'h0000A5A5);
            check("hold_wb_valid", {31'd0, wb_valid}, 32'd1);
            check("hold_s_ready", {31'd0, s_ready}, 32'd0);
            check("hold_ds_ready", {31'd0, ds_ready}, 32'd0);
        end

        // Reset while FULL discards the word and clears counters
        reset = 1'b1;
        tick();
        check("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("midrst_s_cnt", {24'd0, s_cnt}, 32'd0);
        check("midrst_ds_cnt", {24'd0, ds_cnt}, 32'd0);
        check("midrst_ready", {30'd0, s_ready, ds_ready}, 32'd0);

        // Both valid, consumer always ready: tie sequence after reset
        reset    = 1'b0;
        wb_ready = 1'b1;
`ifdef WB_ARB_FIXED_PRIO_EN
        exp_sel = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_sel = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        for (int i = 0; i < 4; i++) begin
            s_data  = 16'h1000 + 16'(i);
            ds_data = 16'h2000 + 16'(i);
            tick();
            check("tie_wb_sel", {31'd0, wb_sel}, {31'd0, exp_sel[i]});
            check("tie_wb_data", {16'd0, wb_data},
                  exp_sel[i] ? 32'h2000 + 32'(i) : 32'h1000 + 32'(i));
        end
        s_valid  = 1'b0;
        ds_valid = 1'b0;
`ifdef WB_ARB_FIXED_PRIO_EN
        check("tie_s_cnt", {24'd0, s_cnt}, 32'd4);
        check("tie_ds_cnt", {24'd0, ds_cnt}, 32'd0);
`else
        check("tie_s_cnt", {24'd0, s_cnt}, 32'd2);
        check("tie_ds_cnt", {24'd0, ds_cnt}, 32'd2);
`endif

        // Saturation of the S counter
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            s_data = 16'($urandom);
            tick();
            if (i == 253) check("sat_s_cnt_254", {24'd0, s_cnt}, 32'd254);
            if (i == 254) check("sat_s_cnt_255", {24'd0, s_cnt}, 32'd255);
        end
        check("sat_s_cnt_end", {24'd0, s_cnt}, 32'd255);
        check("sat_ds_cnt", {24'd0, ds_cnt}, 32'd0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 99) == 0);
            s_valid  = ($urandom_range(0, 2) != 0);
            ds_valid = ($urandom_range(0, 2) != 0);
            s_data   = 16'($urandom);
            ds_data  = 16'($urandom);
            wb_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        reset    = 1'b0;
        s_valid  = 1'b0;
        ds_valid = 1'b0;
        wb_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
